calc_chan_driver: RTL and testbench

- Upstream request driver for one calculator channel (req*_cmd_in / req*_data_in / out_resp* / out_data*).
- Buffers incoming {cmd, op1, op2} requests in a FIFO and issues one request at a time using the two-cycle command protocol.
- Waits for the channel response, or a timeout, and returns the result on a valid/ready response interface.
- Four instances, one per calculator port, sit in front of calc1_top.

---
 rtl/calc_pkg.sv | 34 +++
 rtl/calc_req_fifo.sv | 55 +++++
 rtl/calc_chan_driver.sv | 188 ++++++++++++++++++
 tb/tb_calc_chan_driver.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types for the calculator channel driver.
// Commands, response codes, request bundle, FSM state.
package calc_pkg;

  typedef enum logic [3:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SHL = 4'd5,
    CMD_SHR = 4'd6
  } calc_cmd_e;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_ERR  = 2'd2,
    RESP_INV  = 2'd3
  } calc_resp_e;

  // cmd is raw so invalid codes pass through
  typedef struct packed {
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
  } calc_req_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND_OP2,
    ST_WAIT,
    ST_DONE
  } drv_state_e;

endpackage

// File: rtl/calc_req_fifo.sv
// Show-ahead request FIFO for one calculator channel.
// Full/empty come from the registered count only.
module calc_req_fifo
  import calc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_push,
  input  calc_req_t i_data,
  input  logic      i_pop,
  output calc_req_t o_data,
  output logic      o_full,
  output logic      o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);

  calc_req_t     r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == LP_FULL);
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd];

  // Storage write; contents need no reset
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  // Pointers wrap naturally, count tracks occupancy
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      if (w_push && !w_pop)
        r_cnt <= r_cnt + (AW+1)'(1);
      else if (w_pop && !w_push)
        r_cnt <= r_cnt - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/calc_chan_driver.sv
// Request driver for one calculator channel.
// Issues cmd/op1 then op2, waits for response or timeout.
module calc_chan_driver
  import calc_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 10,
  parameter int CNT_W   = 16
) (
  input  logic             c_clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_cmd,
  input  logic [31:0]      req_op1,
  input  logic [31:0]      req_op2,
  output logic [3:0]       calc_cmd_out,
  output logic [31:0]      calc_data_out,
  input  logic [1:0]       calc_resp_in,
  input  logic [31:0]      calc_data_in,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_resp,
  output logic [31:0]      rsp_data,
  output logic [3:0]       rsp_cmd,
  output logic             rsp_timeout,
  output logic             busy,
  output logic [CNT_W-1:0] timeout_cnt,
  output logic [CNT_W-1:0] stray_cnt
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] LP_TLAST = TW'(TIMEOUT - 1);

  drv_state_e       r_state;
  drv_state_e       w_nxt;
  calc_req_t        w_in;
  calc_req_t        w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_hit;
  logic             w_tmo;
  logic             w_rsp_valid;
  logic             w_busy;
  logic [TW-1:0]    r_timer;
  logic [31:0]      r_op2;
  logic [3:0]       r_cmd_out;
  logic [31:0]      r_data_out;
  logic [1:0]       r_resp;
  logic [31:0]      r_data;
  logic [3:0]       r_cmd;
  logic             r_tmo;
  logic [CNT_W-1:0] r_tcnt;
  logic [CNT_W-1:0] r_scnt;

  assign w_in  = '{cmd: req_cmd, op1: req_op1, op2: req_op2};
  assign w_pop = (r_state == ST_IDLE) && !w_empty;
  assign w_hit = (calc_resp_in != 2'b00);
  assign w_tmo = (r_timer == LP_TLAST) && !w_hit;

  calc_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (c_clk),
    .i_rst   (reset),
    .i_push  (req_valid),
    .i_data  (w_in),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // State register
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_nxt;
  end

  // Next-state logic
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      ST_IDLE:
        if (!w_empty)
          w_nxt = (w_head.cmd == CMD_NOP) ?
                  ST_DONE : ST_SEND_OP2;
      ST_SEND_OP2:
        w_nxt = w_hit ? ST_DONE : ST_WAIT;
      ST_WAIT:
        if (w_hit || w_tmo) w_nxt = ST_DONE;
      ST_DONE:
        if (rsp_ready) w_nxt = ST_IDLE;
      default: w_nxt = ST_IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    w_rsp_valid = (r_state == ST_DONE);
    w_busy      = (r_state != ST_IDLE);
  end

  // Registered channel drive, timer and result capture
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      r_cmd_out  <= '0;
      r_data_out <= '0;
      r_timer    <= '0;
      r_op2      <= '0;
      r_resp     <= '0;
      r_data     <= '0;
      r_cmd      <= '0;
      r_tmo      <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE:
          if (!w_empty) begin
            r_op2 <= w_head.op2;
            r_cmd <= w_head.cmd;
            if (w_head.cmd == CMD_NOP) begin
              r_resp <= RESP_NONE;
              r_data <= '0;
              r_tmo  <= 1'b0;
            end else begin
              r_cmd_out  <= w_head.cmd;
              r_data_out <= w_head.op1;
            end
          end
        ST_SEND_OP2: begin
          r_cmd_out <= '0;
          r_timer   <= '0;
          if (w_hit) begin
            r_data_out <= '0;
            r_resp     <= calc_resp_in;
            r_data     <= calc_data_in;
            r_tmo      <= 1'b0;
          end else begin
            r_data_out <= r_op2;
          end
        end
        ST_WAIT: begin
          r_cmd_out  <= '0;
          r_data_out <= '0;
          if (w_hit) begin
            r_resp <= calc_resp_in;
            r_data <= calc_data_in;
            r_tmo  <= 1'b0;
          end else if (w_tmo) begin
            r_resp <= RESP_NONE;
            r_data <= '0;
            r_tmo  <= 1'b1;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        ST_DONE: ;
        default: ;
      endcase
    end
  end

  // Saturating statistics counters
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      r_tcnt <= '0;
      r_scnt <= '0;
    end else begin
      if (r_state == ST_WAIT && w_tmo && r_tcnt != '1)
        r_tcnt <= r_tcnt + CNT_W'(1);
      if ((r_state == ST_IDLE || r_state == ST_DONE)
          && w_hit && r_scnt != '1)
        r_scnt <= r_scnt + CNT_W'(1);
    end
  end

  assign req_ready     = !w_full;
  assign calc_cmd_out  = r_cmd_out;
  assign calc_data_out = r_data_out;
  assign rsp_valid     = w_rsp_valid;
  assign rsp_resp      = r_resp;
  assign rsp_data      = r_data;
  assign rsp_cmd       = r_cmd;
  assign rsp_timeout   = r_tmo;
  assign busy          = w_busy;
  assign timeout_cnt   = r_tcnt;
  assign stray_cnt     = r_scnt;

endmodule

// File: tb/tb_calc_chan_driver.sv
// Directed bench for calc_chan_driver.
// Bench plays the calculator and checks every step.
module tb_calc_chan_driver;

  logic        c_clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_cmd;
  logic [31:0] req_op1;
  logic [31:0] req_op2;
  logic [3:0]  calc_cmd_out;
  logic [31:0] calc_data_out;
  logic [1:0]  calc_resp_in;
  logic [31:0] calc_data_in;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_resp;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_cmd;
  logic        rsp_timeout;
  logic        busy;
  logic [15:0] timeout_cnt;
  logic [15:0] stray_cnt;

  int n_cmp = 0;
  int n_err = 0;

  calc_chan_driver #(
    .DEPTH(4), .TIMEOUT(10), .CNT_W(16)
  ) dut (
    .c_clk(c_clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_op1(req_op1),
    .req_op2(req_op2),
    .calc_cmd_out(calc_cmd_out),
    .calc_data_out(calc_data_out),
    .calc_resp_in(calc_resp_in),
    .calc_data_in(calc_data_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_resp(rsp_resp), .rsp_data(rsp_data),
    .rsp_cmd(rsp_cmd), .rsp_timeout(rsp_timeout),
    .busy(busy), .timeout_cnt(timeout_cnt),
    .stray_cnt(stray_cnt)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] c,
                      input logic [31:0] a,
                      input logic [31:0] b);
    req_valid = 1'b1;
    req_cmd   = c;
    req_op1   = a;
    req_op2   = b;
    tick();
    req_valid = 1'b0;
  endtask

  // From IDLE with a queued request; reply on first WAIT cycle
  task automatic do_txn(input logic [3:0] c,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] res);
    tick();
    chk("txn_cmd1", 32'(calc_cmd_out), 32'(c));
    chk("txn_op1", calc_data_out, a);
    tick();
    chk("txn_cmd2", 32'(calc_cmd_out), 32'd0);
    chk("txn_op2", calc_data_out, b);
    calc_resp_in = 2'b01;
    calc_data_in = res;
    tick();
    calc_resp_in = 2'b00;
    calc_data_in = '0;
    chk("txn_valid", 32'(rsp_valid), 32'd1);
    chk("txn_cmd", 32'(rsp_cmd), 32'(c));
    chk("txn_data", rsp_data, res);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("txn_drop", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    req_cmd = '0;
    req_op1 = '0;
    req_op2 = '0;
    calc_resp_in = '0;
    calc_data_in = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd", 32'(calc_cmd_out), 32'd0);
    chk("rst_tcnt", 32'(timeout_cnt), 32'd0);
    reset = 1'b0;
    tick();

    // Add, response on second WAIT cycle
    push(4'd1, 32'h64, 32'h27);
    tick();
    chk("add_cmd1", 32'(calc_cmd_out), 32'd1);
    chk("add_op1", calc_data_out, 32'h64);
    chk("add_busy", 32'(busy), 32'd1);
    tick();
    chk("add_cmd2", 32'(calc_cmd_out), 32'd0);
    chk("add_op2", calc_data_out, 32'h27);
    tick();
    chk("add_wait0", calc_data_out, 32'd0);
    chk("add_wait_v", 32'(rsp_valid), 32'd0);
    calc_resp_in = 2'b01;
    calc_data_in = 32'h8B;
    tick();
    calc_resp_in = 2'b00;
    calc_data_in = '0;
    chk("add_valid", 32'(rsp_valid), 32'd1);
    chk("add_resp", 32'(rsp_resp), 32'd1);
    chk("add_data", rsp_data, 32'h8B);
    chk("add_tmo", 32'(rsp_timeout), 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("add_drop", 32'(rsp_valid), 32'd0);

    // Timeout: 10 cycles after WAIT entry
    push(4'd1, 32'h5, 32'h1);
    tick();
    tick();
    for (int i = 0; i < 9; i++) tick();
    chk("to_early", 32'(rsp_valid), 32'd0);
    tick();
    chk("to_valid", 32'(rsp_valid), 32'd1);
    chk("to_resp", 32'(rsp_resp), 32'd0);
    chk("to_flag", 32'(rsp_timeout), 32'd1);
    chk("to_cnt", 32'(timeout_cnt), 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Overflow, then stall in DONE while filling FIFO
    push(4'd1, 32'hFFFFFFFF, 32'h1);
    tick();
    tick();
    calc_resp_in = 2'b10;
    calc_data_in = 32'h0;
    tick();
    calc_resp_in = 2'b00;
    chk("ov_resp", 32'(rsp_resp), 32'd2);
    chk("ov_tmo", 32'(rsp_timeout), 32'd0);
    push(4'd1, 32'h1, 32'h2);
    push(4'd2, 32'h5, 32'h2);
    push(4'd5, 32'h3, 32'h2);
    chk("ff_ready3", 32'(req_ready), 32'd1);
    push(4'd6, 32'hC, 32'h2);
    chk("ff_full", 32'(req_ready), 32'd0);
    push(4'd3, 32'h9, 32'h9);
    chk("ff_full2", 32'(req_ready), 32'd0);
    chk("bp_valid", 32'(rsp_valid), 32'd1);
    chk("bp_resp", 32'(rsp_resp), 32'd2);
    chk("bp_data", rsp_data, 32'd0);
    chk("bp_cmd", 32'(calc_cmd_out), 32'd0);
    chk("bp_odata", calc_data_out, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rel_valid", 32'(rsp_valid), 32'd0);
    do_txn(4'd1, 32'h1, 32'h2, 32'h3);
    do_txn(4'd2, 32'h5, 32'h2, 32'h3);
    do_txn(4'd5, 32'h3, 32'h2, 32'hC);
    do_txn(4'd6, 32'hC, 32'h2, 32'h3);
    tick();
    chk("ff_empty", 32'(busy), 32'd0);
    chk("ff_ready", 32'(req_ready), 32'd1);
    chk("st_zero", 32'(stray_cnt), 32'd0);

    // Stray in IDLE, then no-op and stray in DONE
    calc_resp_in = 2'b01;
    tick();
    calc_resp_in = 2'b00;
    chk("st_idle", 32'(stray_cnt), 32'd1);
    push(4'd0, 32'h7, 32'h9);
    tick();
    chk("nop_valid", 32'(rsp_valid), 32'd1);
    chk("nop_resp", 32'(rsp_resp), 32'd0);
    chk("nop_data", rsp_data, 32'd0);
    chk("nop_tmo", 32'(rsp_timeout), 32'd0);
    chk("nop_cmd", 32'(calc_cmd_out), 32'd0);
    calc_resp_in = 2'b01;
    calc_data_in = 32'h77;
    tick();
    calc_resp_in = 2'b00;
    calc_data_in = '0;
    chk("st_done", 32'(stray_cnt), 32'd2);
    chk("st_ignored", rsp_data, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Asynchronous reset in WAIT
    push(4'd2, 32'h9, 32'h4);
    tick();
    tick();
    chk("rw_busy", 32'(busy), 32'd1);
    push(4'd1, 32'h2, 32'h2);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_cmd", 32'(calc_cmd_out), 32'd0);
    chk("ar_data", calc_data_out, 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_ready", 32'(req_ready), 32'd1);
    chk("ar_tcnt", 32'(timeout_cnt), 32'd0);
    chk("ar_scnt", 32'(stray_cnt), 32'd0);
    chk("ar_resp", 32'(rsp_resp), 32'd0);
    tick();
    reset = 1'b0;
    calc_resp_in = 2'b01;
    calc_data_in = 32'h55;
    tick();
    calc_resp_in = 2'b00;
    calc_data_in = '0;
    chk("ar_late_v", 32'(rsp_valid), 32'd0);
    chk("ar_late_d", rsp_data, 32'd0);
    tick();
    tick();
    chk("ar_fifo", 32'(busy), 32'd0);
    chk("ar_cmd2", 32'(calc_cmd_out), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
